magcomp_serial: RTL
===================

Name: magcomp_serial

Overview:
Parametrised, bit-serial magnitude comparator; successor to the 2-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, one bit per clock.
- Operands are captured on a start/busy/done handshake; supports unsigned and two's-complement modes.
- Produces the same one-hot AGB/AEB/ALB result triple.
- Used where a wide compare must be area-cheap and latency-tolerant.

Parameters:
WIDTH, 8, operand width in bits; legal range >= 2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a compare; sampled only when not busy.
mode_signed  input  1  0 = unsigned, 1 = two's-complement; latched with the operands.
A  input  WIDTH  operand A; latched on an accepted start.
B  input  WIDTH  operand B; latched on an accepted start.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse: result registers have just been updated.
AGB  output  1  A > B.
AEB  output  1  A == B.
ALB  output  1  A < B.

Behaviour:
- Reset: one clock, synchronous reset, active-high (rst sampled on rising clk).
  - Reset state: IDLE; busy=0, done=0, AGB=AEB=ALB=0, internal registers cleared.
  - rst dominates start.
- States:
  - IDLE: busy=0. On start=1, latch A, B and mode_signed; bit index := WIDTH-1; go to COMPARE.
  - COMPARE: busy=1. Each cycle, examine bit[index] of both latched operands.
    - First differing bit only: record provisional gt/lt.
      - Unsigned: the operand with 1 is greater.
      - Signed, index == WIDTH-1: the operand with 1 is LESS.
      - Signed, lower bits: the operand with 1 is greater.
    - Later differing bits do not change the record.
    - At index 0, go to DONE; otherwise decrement index.
  - DONE: busy=0, done=1 for exactly one cycle.
    - AGB/AEB/ALB are loaded on the edge entering DONE.
    - AEB=1 if no bit differed.
    - Next state is IDLE, or COMPARE if start=1 in this cycle (back-to-back accepted).
- Latency:
  - start sampled at edge k; bits processed at edges k+1..k+WIDTH.
  - Entry into DONE (done high, results valid) occurs at edge k+WIDTH.
  - done is observable during the cycle after that edge.
- Output rules:
  - Results hold their value until the next DONE entry.
  - After the first completed compare, exactly one of AGB/AEB/ALB is 1.
  - Results are never modified while busy.
- Boundary conditions:
  - start while busy: ignored; operands and mode are not re-latched.
  - A/B/mode_signed changing during COMPARE: no effect.
  - rst mid-COMPARE: aborts, no done pulse, outputs return to reset values.
  - WIDTH=2 must reproduce the legacy 2-bit comparator truth table (unsigned).
  - Signed boundaries: all-ones vs zero is ALB (-1 < 0); 100..0 is the minimum value.

Optional Feature:
Macro MAGCOMP_EARLY_EXIT_EN.
- Defined:
  - COMPARE goes to DONE on the edge that examines the first differing bit.
  - For a first difference at index i, DONE is entered at edge k+(WIDTH-i).
  - Equal operands still take WIDTH cycles.
- Undefined:
  - Fixed latency of WIDTH cycles regardless of data.
  - Identical results in both builds; only timing differs.

Test Plan:
1. WIDTH=8, rst 2 cycles, unsigned, A=8'h5A, B=8'h5A, start 1 cycle
   -> busy high 8 cycles; done pulses once, 8 edges after start; AEB=1, AGB=ALB=0.
2. Unsigned, A=8'h80, B=8'h7F
   -> AGB=1. Signed, same operands -> ALB=1 (-128 < 127). Signed, A=8'hFF, B=8'h00 -> ALB=1.
3. Start A=8'h03, B=8'h05. At the 3rd busy cycle, drive start=1 with A=8'h09, B=8'h01
   -> second start ignored; single done; ALB=1.
4. Start A=8'h10, B=8'h20; assert rst at the 4th busy cycle
   -> busy=0 next edge; no done pulse; AGB=AEB=ALB=0.
5. WIDTH=2: all 16 unsigned (A,B) pairs, 00..11 x 00..11, with back-to-back starts issued in the done cycle
   -> results match the legacy truth table; no lost or duplicated done pulses.
6. With MAGCOMP_EARLY_EXIT_EN defined: A=8'h80, B=8'h00 -> done 1 edge after start, AGB=1.
   - A=8'h01, B=8'h00 -> done 8 edges after start, AGB=1.
   - A=8'h00, B=8'h00 -> done 8 edges after start, AEB=1.

Source files
------------

// File: rtl/magcomp_serial.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake, unsigned or two's-complement.
// Optional build macro MAGCOMP_EARLY_EXIT_EN: finish on the first differing bit instead of after WIDTH bits.
module magcomp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AGB,
  output logic             AEB,
  output logic             ALB
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic            sgn_q;
  logic [IW-1:0]   idx;
  logic            found_q, gt_q;

  logic a_bit, b_bit, diff, found_nxt, gt_nxt, last, accept, finish;

  // A differing sign bit inverts the sense: the operand holding the 1 is negative.
  function automatic logic first_gt(input logic abit, input logic bbit, input logic sign_pos);
    return sign_pos ? bbit : abit;
  endfunction

  assign a_bit = a_q[idx];
  assign b_bit = b_q[idx];
  assign busy  = (state == COMPARE);
  assign done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    diff      = a_bit ^ b_bit;
    last      = (idx == '0);
    found_nxt = found_q | diff;
    gt_nxt    = found_q ? gt_q : (diff & first_gt(a_bit, b_bit, sgn_q && (idx == IDX_MSB)));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
`ifdef MAGCOMP_EARLY_EXIT_EN
        if (last || (diff && !found_q)) begin
`else
        if (last) begin
`endif
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = COMPARE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx     <= '0;
      found_q <= 1'b0;
      gt_q    <= 1'b0;
      AGB     <= 1'b0;
      AEB     <= 1'b0;
      ALB     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        sgn_q   <= mode_signed;
        idx     <= IDX_MSB;
        found_q <= 1'b0;
        gt_q    <= 1'b0;
      end else if (state == COMPARE) begin
        found_q <= found_nxt;
        gt_q    <= gt_nxt;
        if (!last) idx <= idx - 1'b1;
      end
      // Result triple is only touched on the edge entering DONE.
      if (finish) begin
        AGB <= found_nxt & gt_nxt;
        ALB <= found_nxt & ~gt_nxt;
        AEB <= ~found_nxt;
      end
    end
  end

endmodule
